// File: rtl/disk_server_pkg.sv
`default_nettype none
// ============================================================================
// Module : disk_server_pkg
// Brief  : Shared constants and state encoding for the UART sector protocol.
// Rev    : 1.0  initial release
// ============================================================================
package disk_server_pkg;

    localparam logic [7:0] ACK_OK  = 8'hFF;
    localparam logic [7:0] ACK_NAK = 8'h00;
    localparam logic [7:0] BYE_OK  = 8'hFF;

    localparam int SECTOR_BYTES = 512;

    localparam int DEV_SEL   = 31;
    localparam int DIR_WRITE = 30;
    localparam int UART_SEL  = 29;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_RECV  = 3'd4,
        ST_BYE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/disk_server_mem.sv
`default_nettype none
// ============================================================================
// Module : disk_server_mem
// Brief  : Byte RAM with a protocol port and a backdoor port, single clock.
// Rev    : 1.0  initial release
// ============================================================================
module disk_server_mem #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic              i_a_we,
    input  logic              i_a_re,
    input  logic [7:0]        i_a_wdata,
    output logic [7:0]        o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic              i_b_we,
    input  logic [7:0]        i_b_wdata,
    output logic [7:0]        o_b_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Storage is deliberately left out of reset so it survives a mid-transfer rst.
    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a_rdata <= 8'h00;
            o_b_rdata <= 8'h00;
        end else begin
            if (i_a_re) begin
                o_a_rdata <= r_mem[i_a_addr];
            end
            o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/disk_server.sv
`default_nettype none
// ============================================================================
// Module : disk_server
// Brief  : Responder for the 4-byte-request UART sector protocol, serving
//          512-byte sectors from internal storage with a backdoor port.
// Rev    : 1.0  initial release
// ============================================================================
module disk_server
    import disk_server_pkg::*;
#(
    parameter int SECTORS        = 8,
    parameter int SECTOR_W       = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    rx_valid,
    input  logic [7:0]                              rx_data,
    output logic                                    tx_valid,
    output logic [7:0]                              tx_data,
    input  logic                                    tx_ready,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    input  logic                                    bd_we,
    input  logic [$clog2(SECTORS*SECTOR_BYTES)-1:0] bd_addr,
    input  logic [7:0]                              bd_wdata,
    output logic [7:0]                              bd_rdata
);

    localparam int ADDR_W = $clog2(SECTORS*SECTOR_BYTES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES+1);
    localparam int SW1    = SECTOR_W + 1;

    localparam logic [SECTOR_W:0] c_SECTOR_LIMIT = SW1'(SECTORS);
    localparam logic [TMO_W-1:0]  c_TMO_LAST     = TMO_W'(TIMEOUT_CYCLES-1);

    state_t               r_state;
    logic [1:0]           r_req_idx;
    logic [23:0]          r_req;
    logic [SECTOR_W-1:0]  r_sector;
    logic                 r_write;
    logic [7:0]           r_ack_byte;
    logic [9:0]           r_cnt;
    logic [TMO_W-1:0]     r_tmo;

    logic [31:0]          w_instr;
    logic [SECTOR_W-1:0]  w_req_sector;
    logic                 w_req_ok;
    logic                 w_unused;
    logic                 w_tx_fire;
    logic                 w_evt;
    logic                 w_busy;
    logic                 w_tmo_hit;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [7:0]           w_mem_q;

    // The fourth request byte is decoded straight off the wire.
    assign w_instr      = {rx_data, r_req};
    assign w_req_sector = w_instr[SECTOR_W-1:0];
    assign w_req_ok     = w_instr[DEV_SEL] & w_instr[UART_SEL]
                        & ({1'b0, w_req_sector} < c_SECTOR_LIMIT);
    assign w_unused     = ^w_instr[28:SECTOR_W];

    assign w_tx_fire = tx_valid & tx_ready;
    assign w_evt     = rx_valid | w_tx_fire;
    assign w_busy    = !((r_state == ST_IDLE) && (r_req_idx == 2'd0));
    assign w_tmo_hit = w_busy & ~w_evt & (r_tmo == c_TMO_LAST);

    assign w_mem_addr = ADDR_W'({r_sector, r_cnt[8:0]});
    assign w_mem_we   = (r_state == ST_RECV) & rx_valid;
    assign w_mem_re   = (r_state == ST_FETCH);

    assign busy    = w_busy;
    assign tx_data = (r_state == ST_SEND) ? w_mem_q : r_ack_byte;

    disk_server_mem #(
        .DEPTH  (SECTORS*SECTOR_BYTES),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_a_addr  (w_mem_addr),
        .i_a_we    (w_mem_we),
        .i_a_re    (w_mem_re),
        .i_a_wdata (rx_data),
        .o_a_rdata (w_mem_q),
        .i_b_addr  (bd_addr),
        .i_b_we    (bd_we & ~w_busy),
        .i_b_wdata (bd_wdata),
        .o_b_rdata (bd_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_idx  <= 2'd0;
            r_req      <= 24'h0;
            r_sector   <= '0;
            r_write    <= 1'b0;
            r_ack_byte <= 8'h00;
            r_cnt      <= 10'd0;
            r_tmo      <= '0;
            tx_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (w_evt || !w_busy || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_tmo_hit) begin
                err       <= 1'b1;
                r_state   <= ST_IDLE;
                r_req_idx <= 2'd0;
                tx_valid  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            r_req_idx <= r_req_idx + 2'd1;
                            if (r_req_idx == 2'd3) begin
                                r_sector   <= w_req_sector;
                                r_write    <= w_instr[DIR_WRITE];
                                r_ack_byte <= w_req_ok ? ACK_OK : ACK_NAK;
                                tx_valid   <= 1'b1;
                                r_state    <= ST_ACK;
                            end else begin
                                r_req[{r_req_idx, 3'b000} +: 8] <= rx_data;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_tx_fire) begin
                            tx_valid <= 1'b0;
                            r_cnt    <= 10'd0;
                            if (r_ack_byte != ACK_OK) begin
                                r_state <= ST_IDLE;
                            end else if (r_write) begin
                                r_state <= ST_RECV;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        tx_valid <= 1'b1;
                        r_state  <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (w_tx_fire) begin
                            tx_valid <= 1'b0;
                            r_cnt    <= r_cnt + 10'd1;
                            r_state  <= (r_cnt == 10'd511) ? ST_BYE : ST_FETCH;
                        end
                    end
                    ST_RECV: begin
                        if (rx_valid) begin
                            r_cnt <= r_cnt + 10'd1;
                            if (r_cnt == 10'd511) begin
                                r_state <= ST_BYE;
                            end
                        end
                    end
                    ST_BYE: begin
                        if (rx_valid) begin
                            done    <= (rx_data == BYE_OK);
                            err     <= (rx_data != BYE_OK);
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disk_server.sv
`default_nettype none
// ============================================================================
// Module : tb_disk_server
// Brief  : Scoreboard bench for disk_server: directed requests, queued
//          expected tx bytes and done/err events checked by a monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_disk_server;

    localparam int SECTORS  = 8;
    localparam int SECTOR_W = 4;
    localparam int TMO      = 100;
    localparam int AW       = 12;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 1;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;

    int         n_checks;
    int         n_fail;
    int         n_tx;
    logic [7:0] exp_tx[$];
    int         exp_ev[$];

    disk_server #(
        .SECTORS        (SECTORS),
        .SECTOR_W       (SECTOR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k, input int i);
        case (k)
            0:       return 8'(i);
            1:       return 8'(i) ^ 8'hA5;
            2:       return 8'h5A;
            3:       return 8'(i * 3);
            default: return 8'(i) ^ 8'h3C;
        endcase
    endfunction

    // Monitor: inputs change only at posedge+1, so a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
                n_tx++;
            end
            if (done || err) begin
                if (exp_ev.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ev_unexpected: got done=%0b err=%0b, expected none", done, err);
                end else begin
                    check("done_err_event", {30'h0, done, err}, 32'(exp_ev.pop_front()));
                end
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic request(input logic [7:0] b0, input logic [7:0] b3, input logic [7:0] ack);
        exp_tx.push_back(ack);
        send_rx(b0);
        send_rx(8'h00);
        send_rx(8'h00);
        send_rx(b3);
    endtask

    task automatic wait_tx(input int target, input string name);
        int k;
        k = 0;
        while (n_tx < target && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_tx < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: %0d tx bytes seen, needed %0d", name, n_tx, target);
        end
    endtask

    task automatic bd_write(input int a, input logic [7:0] d);
        bd_addr  = AW'(a);
        bd_wdata = d;
        bd_we    = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic bd_check(input int a, input logic [7:0] exp, input string name);
        bd_addr = AW'(a);
        @(posedge clk);
        #1;
        check(name, {24'h0, bd_rdata}, {24'h0, exp});
    endtask

    task automatic read_sector(input int sec, input int kind, input bit stall);
        int base;
        base = n_tx;
        request(8'(sec), 8'hA0, 8'hFF);
        for (int i = 0; i < 512; i++) exp_tx.push_back(pat(kind, i));
        if (stall) begin
            wait_tx(base + 18, "wait_byte17");
            tx_ready = 1'b0;
            repeat (50) begin
                @(posedge clk);
                #1;
                check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
                check("stall_tx_data", {24'h0, tx_data}, {24'h0, pat(kind, 17)});
            end
            tx_ready = 1'b1;
        end
        wait_tx(base + 513, "wait_read_sector");
        exp_ev.push_back(EV_DONE);
        send_rx(8'hFF);
        check("busy_after_read", {31'h0, busy}, 32'h0);
    endtask

    task automatic write_sector(input int sec, input int kind, input logic [7:0] bye);
        int base;
        base = n_tx;
        request(8'(sec), 8'hE0, 8'hFF);
        wait_tx(base + 1, "wait_write_ack");
        for (int i = 0; i < 512; i++) send_rx(pat(kind, i));
        exp_ev.push_back((bye == 8'hFF) ? EV_DONE : EV_ERR);
        send_rx(bye);
        check("busy_after_write", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 512; i++) bd_check(sec * 512 + i, pat(kind, i), "write_data");
    endtask

    initial begin
        int n;
        int base;
        n_checks = 0;
        n_fail   = 0;
        n_tx     = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_bd_rdata", {24'h0, bd_rdata}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 512; i++) bd_write(2 * 512 + i, pat(0, i));
        for (int i = 0; i < 512; i++) bd_write(1 * 512 + i, pat(1, i));

        // Read sector 2 with a 50-cycle tx_ready stall on byte 17
        read_sector(2, 0, 1'b1);

        // Write sector 5 with 0x5A and a good goodbye
        write_sector(5, 2, 8'hFF);

        // Out-of-range sector is nak'd, then a retry on sector 1 succeeds
        base = n_tx;
        request(8'h09, 8'hA0, 8'h00);
        wait_tx(base + 1, "wait_nak");
        check("busy_after_nak", {31'h0, busy}, 32'h0);
        read_sector(1, 1, 1'b0);

        // Bad goodbye: err, no done, data kept
        write_sector(4, 3, 8'h00);

        // Partial request then silence: err exactly TMO cycles after the last byte
        exp_ev.push_back(EV_ERR);
        send_rx(8'h02);
        send_rx(8'h00);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (err) break;
        end
        check("timeout_cycles", 32'(n), 32'(TMO));
        check("busy_after_timeout", {31'h0, busy}, 32'h0);
        read_sector(2, 0, 1'b0);

        // Reset while receiving byte 200 of a write
        base = n_tx;
        request(8'h03, 8'hE0, 8'hFF);
        wait_tx(base + 1, "wait_ack_before_rst");
        for (int i = 0; i < 200; i++) send_rx(pat(4, i));
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_bd_rdata", {24'h0, bd_rdata}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) bd_check(3 * 512 + i, pat(4, i), "partial_write_kept");
        write_sector(3, 4, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        check("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
        check("event_queue_drained", 32'(exp_ev.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
